ram_ctrl: RTL and testbench
===========================

# ram_ctrl

Two-client initiator that drives one port of the parser's dual-port message RAM. It arbitrates read and write requests from two valid/ready clients: the FIX field writer (client 0) and the field lookup reader (client 1). It sequences the RAM chip-select, write-enable and output-enable strobes, and returns read data over a valid/ready response channel. It sits between the parser datapath and the RAM, and is the only logic that drives that RAM port.

## Interface
- ADDR_WIDTH, 8, RAM address width
- DATA_WIDTH, 32, RAM word width
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  per-client request valid, bit i = client i
- req_ready  out  2  per-client request accept
- req_we  in  2  1 = write, 0 = read
- req_addr  in  2×ADDR_WIDTH  per-client address
- req_wdata  in  2×DATA_WIDTH  per-client write data
- rsp_valid  out  2  read data valid, one-hot or zero
- rsp_ready  in  2  per-client response accept
- rsp_rdata  out  DATA_WIDTH  read data, shared by both clients, qualified by rsp_valid
- ram_cs, ram_we, ram_oe  out  1 each  RAM port strobes, all registered
- ram_addr  out  ADDR_WIDTH  registered RAM address
- ram_wdata  out  DATA_WIDTH  registered write data; top level performs the bidirectional tie
- ram_rdata  in  DATA_WIDTH  RAM port data as driven by the RAM

## Operation
- FSM states: IDLE, WR, RD0, RD1, RSP.
- IDLE:
  - Grants at most one client. req_ready[g] = req_valid[g] & grant[g], only in IDLE.
  - On handshake, latches we, addr and wdata, then goes to WR (write) or RD0 (read).
- WR: ram_cs=1, ram_we=1, ram_oe=0 for exactly one cycle, then IDLE.
- RD0: ram_cs=1, ram_we=0, ram_oe=1. The RAM registers the word at the end of this cycle. Next state RD1.
- RD1: strobes held. rsp_rdata captures ram_rdata at the end of RD1. Next state RSP.
- RSP: strobes deasserted. rsp_valid[g]=1 and rsp_rdata are stable until rsp_ready[g]. Then IDLE.
- No new request is accepted while a transaction is in flight. At most one outstanding operation.
- ram_addr and ram_wdata hold their last value when idle. ram_cs=0 in IDLE and RSP.
- Reset values: state=IDLE, all strobes 0, ram_addr=0, ram_wdata=0, rsp_valid=0, rsp_rdata=0, rr pointer=0.
- Reset mid-operation:
  - A strobe already presented during the reset cycle is sampled by the RAM at that edge, so a WR-cycle write completes.
  - Any pending read or response is discarded and the FSM returns to IDLE.
- A client deasserting req_valid before its handshake is legal; no grant state is retained.

## Timing
- Write: handshake at edge N, strobes high during cycle N+1. The client may reissue at edge N+2, so one write every 2 cycles.
- Read: handshake at edge N, RD0 in N+1, RD1 in N+2, rsp_valid high from cycle N+3. Read latency is 3 cycles from handshake to rsp_valid.
- Response back-pressure: rsp_valid is held indefinitely. The next request is accepted no earlier than the cycle after the response handshake.
- All outputs except req_ready come from registers. req_ready is combinational from req_valid, the state and the grant.

## Configuration
- RAM_CTRL_RR_EN defined:
  - Round-robin arbitration. When both clients are valid in IDLE, the client not granted last is chosen.
  - The pointer updates on every request handshake.
- RAM_CTRL_RR_EN undefined: fixed priority, client 0 always wins on simultaneous requests. The pointer logic is not compiled.

## Structure
- Shared package ram_ctrl_pkg holds:
  - the state enum typedef (IDLE, WR, RD0, RD1, RSP)
  - NUM_CLIENTS=2
  - the read latency constant RD_LAT=3
- One sub-module, ram_ctrl_arb: a two-requester arbiter taking req_valid, an accept pulse and the state, and producing a one-hot grant. It contains the round-robin pointer under RAM_CTRL_RR_EN.

## Test plan
- Reset release, then client 0 writes addr 0x10 data 0xDEADBEEF → ram_cs=ram_we=1 and ram_addr=0x10 for exactly one cycle, one cycle after the handshake.
- Client 1 reads 0x10 after that write, with rsp_ready=1 → rsp_valid[1]=1 and rsp_rdata=0xDEADBEEF three cycles after the handshake, rsp_valid[0] stays 0.
- Client 0 read with rsp_ready held 0 for 5 cycles → rsp_valid and rsp_rdata stable throughout, req_ready=0 for both clients, handshake on the 6th cycle, then return to IDLE.
- Both clients valid continuously, 4 writes each:
  - with RAM_CTRL_RR_EN, grants alternate 0,1,0,1…
  - without it, all client 0 writes complete before client 1 is granted.
- rst asserted during RD1 → next cycle state IDLE, ram_cs=0, rsp_valid=0, and no response is ever delivered for that read.
- Write 0x5 to addr 0xFF then read 0xFF, plus wrap check: addr 0x00 is unaffected (read returns its prior value).

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared types and constants for the message-RAM port controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: controller state enum, client count, read latency (accept to rsp_valid).
package ram_ctrl_pkg;

  localparam int NUM_CLIENTS = 2;

  // Cycles from request handshake to rsp_valid for a read.
  localparam int RD_LAT = 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD0  = 3'd2,
    RD1  = 3'd3,
    RSP  = 3'd4
  } state_t;

endpackage

// File: rtl/ram_ctrl_if.sv
// ram_ctrl_if: client request/response channels of the message-RAM controller.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the request and the response channel.
// Modports: slave = controller side, master = client side (both clients, bit i = client i).
interface ram_ctrl_if
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);

  logic [NUM_CLIENTS-1:0]                 req_valid;
  logic [NUM_CLIENTS-1:0]                 req_ready;
  logic [NUM_CLIENTS-1:0]                 req_we;
  logic [NUM_CLIENTS-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0] req_wdata;
  logic [NUM_CLIENTS-1:0]                 rsp_valid;
  logic [NUM_CLIENTS-1:0]                 rsp_ready;
  logic [DATA_WIDTH-1:0]                  rsp_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/ram_ctrl_arb.sv
// ram_ctrl_arb: two-requester arbiter producing a one-hot grant, only while the controller is IDLE.
// Latency: combinational grant; round-robin pointer updates on the accept edge.
// Backpressure: grant is zero outside IDLE, so no request is accepted while an op is in flight.
// Ports: clk/rst; req_valid (per client); accept (request handshake pulse); state; grant (one-hot or zero).
// Build option: RAM_CTRL_RR_EN selects round-robin; otherwise client 0 has fixed priority.
module ram_ctrl_arb
  import ram_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CLIENTS-1:0] req_valid,
  input  logic                   accept,
  input  state_t                 state,
  output logic [NUM_CLIENTS-1:0] grant
);

`ifdef RAM_CTRL_RR_EN
  // Client that wins a tie; always the one not granted on the last handshake.
  logic rr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (accept) begin
      rr_ptr <= ~grant[1];
    end
  end

  always_comb begin
    grant = '0;
    if (state == IDLE) begin
      if (req_valid[0] && (!req_valid[1] || !rr_ptr)) begin
        grant = 2'b01;
      end else if (req_valid[1]) begin
        grant = 2'b10;
      end
    end
  end
`else
  // Fixed priority needs no state; keep the shared port list tidy.
  logic unused_arb;
  assign unused_arb = ^{clk, rst, accept};

  always_comb begin
    grant = '0;
    if (state == IDLE) begin
      if (req_valid[0]) begin
        grant = 2'b01;
      end else if (req_valid[1]) begin
        grant = 2'b10;
      end
    end
  end
`endif

endmodule

// File: rtl/ram_ctrl.sv
// ram_ctrl: sole initiator of one message-RAM port, serving the field writer (0) and field lookup reader (1).
// Latency: write strobes in the cycle after accept; read data on rsp_valid 3 cycles after accept.
// Backpressure: one op in flight, req_ready low outside IDLE; rsp_valid/rsp_rdata held until rsp_ready.
// Ports: clk/rst; bus (ram_ctrl_if.slave) client req/rsp; ram_cs/ram_we/ram_oe/ram_addr/ram_wdata out, ram_rdata in.
// Build option: RAM_CTRL_RR_EN enables round-robin arbitration between the two clients.
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
)
(
  input  logic                  clk,
  input  logic                  rst,
  ram_ctrl_if.slave             bus,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  state_t                 state;
  logic [NUM_CLIENTS-1:0] grant;
  logic                   accept;
  logic                   gidx;  // index of the granted client this cycle
  logic                   cur;   // client owning the op in flight

  ram_ctrl_arb u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_valid (bus.req_valid),
    .accept    (accept),
    .state     (state),
    .grant     (grant)
  );

  // grant is already zero outside IDLE.
  assign bus.req_ready = bus.req_valid & grant;
  assign accept        = |bus.req_ready;
  assign gidx          = grant[1];

  // Strobes are registered alongside the state so they line up with it exactly.
  // A reset edge still sees the strobes presented in that cycle, so an in-progress
  // WR completes at the RAM while reads and responses are simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cur           <= 1'b0;
      ram_cs        <= 1'b0;
      ram_we        <= 1'b0;
      ram_oe        <= 1'b0;
      ram_addr      <= '0;
      ram_wdata     <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cur       <= gidx;
            ram_addr  <= bus.req_addr[gidx];
            ram_wdata <= bus.req_wdata[gidx];
            ram_cs    <= 1'b1;
            if (bus.req_we[gidx]) begin
              ram_we <= 1'b1;
              ram_oe <= 1'b0;
              state  <= WR;
            end else begin
              ram_we <= 1'b0;
              ram_oe <= 1'b1;
              state  <= RD0;
            end
          end
        end
        WR: begin
          ram_cs <= 1'b0;
          ram_we <= 1'b0;
          state  <= IDLE;
        end
        RD0: begin
          // RAM registers the word at the end of this cycle; strobes stay up.
          state <= RD1;
        end
        RD1: begin
          bus.rsp_rdata <= ram_rdata;
          bus.rsp_valid <= NUM_CLIENTS'(1) << cur;
          ram_cs        <= 1'b0;
          ram_oe        <= 1'b0;
          state         <= RSP;
        end
        RSP: begin
          if (bus.rsp_ready[cur]) begin
            bus.rsp_valid <= '0;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: directed vectors plus hand-written sequences around ram_ctrl with a small synchronous RAM model.
// Latency: n/a.
// Backpressure: exercises held responses and simultaneous requests.
module tb_ram_ctrl;
  import ram_ctrl_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_init = 1'b1;

  always #5 clk = ~clk;

  ram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  logic          ram_cs, ram_we, ram_oe;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_oe    (ram_oe),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // Synchronous RAM: writes and read-registers on the clock edge the strobes are sampled.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
    end else if (ram_cs && ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    if (ram_cs && ram_oe && !ram_we) ram_rdata <= mem[ram_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Waits (bounded) for client c to see req_ready, then steps to just after the handshake edge.
  task automatic wait_grant(input int c, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready[c]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL grant_timeout: client %0d never got req_ready", c);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok;
    bus.req_valid    = '0;
    bus.req_valid[c] = 1'b1;
    bus.req_we[c]    = 1'b1;
    bus.req_addr[c]  = a;
    bus.req_wdata[c] = d;
    wait_grant(c, ok);
    bus.req_valid = '0;
    if (!ok) return;
    chk("wr_cs",    ram_cs,    1'b1);
    chk("wr_we",    ram_we,    1'b1);
    chk("wr_oe",    ram_oe,    1'b0);
    chk("wr_addr",  ram_addr,  a);
    chk("wr_wdata", ram_wdata, d);
    @(posedge clk);
    #1;
    chk("wr_cs_one_cycle", ram_cs, 1'b0);
    chk("wr_we_one_cycle", ram_we, 1'b0);
  endtask

  // Read with rsp_ready held low for 'hold' cycles after rsp_valid rises;
  // during the hold both clients request and must not be accepted.
  task automatic do_read(input int c, input logic [AW-1:0] a, input logic [DW-1:0] exp, input int hold);
    bit ok;
    logic [1:0] exp_vld;
    exp_vld = 2'b00;
    exp_vld[c] = 1'b1;
    bus.rsp_ready    = 2'b11;
    bus.rsp_ready[c] = (hold == 0);
    bus.req_valid    = '0;
    bus.req_valid[c] = 1'b1;
    bus.req_we[c]    = 1'b0;
    bus.req_addr[c]  = a;
    wait_grant(c, ok);
    bus.req_valid = '0;
    if (!ok) return;
    for (int k = 1; k < RD_LAT; k++) begin
      chk("rd_cs",       ram_cs,        1'b1);
      chk("rd_oe",       ram_oe,        1'b1);
      chk("rd_we",       ram_we,        1'b0);
      chk("rd_addr",     ram_addr,      a);
      chk("rd_no_early", bus.rsp_valid, 2'b00);
      @(posedge clk);
      #1;
    end
    chk("rsp_valid", bus.rsp_valid, exp_vld);
    chk("rsp_rdata", bus.rsp_rdata, exp);
    chk("rsp_cs",    ram_cs,        1'b0);
    for (int k = 0; k < hold; k++) begin
      bus.req_valid = 2'b11;
      bus.req_we    = 2'b00;
      @(negedge clk);
      chk("hold_rsp_valid", bus.rsp_valid, exp_vld);
      chk("hold_rsp_rdata", bus.rsp_rdata, exp);
      chk("hold_req_ready", bus.req_ready, 2'b00);
      @(posedge clk);
      #1;
    end
    bus.req_valid    = '0;
    bus.rsp_ready[c] = 1'b1;
    if (hold != 0) chk("hold_last_valid", bus.rsp_valid, exp_vld);
    @(posedge clk);
    #1;
    chk("rsp_drop",    bus.rsp_valid, 2'b00);
    chk("rsp_to_idle", dut.state,     IDLE);
  endtask

  typedef struct {
    logic          we;
    int            client;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];
  int   order[$];
  int   cnt[2];

  initial begin
    vecs[0] = '{1'b1, 0, 8'h10, 32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{1'b0, 1, 8'h10, 32'h0,         32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 0, 8'hFF, 32'h0000_0005, 32'h0};
    vecs[3] = '{1'b0, 1, 8'hFF, 32'h0,         32'h0000_0005};
    vecs[4] = '{1'b0, 0, 8'h00, 32'h0,         32'hA500_0000};
    vecs[5] = '{1'b1, 1, 8'h01, 32'h1234_5678, 32'h0};
    vecs[6] = '{1'b0, 0, 8'h01, 32'h0,         32'h1234_5678};
    vecs[7] = '{1'b0, 1, 8'h02, 32'h0,         32'hA500_0002};

    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = '0;
    rst      = 1'b1;
    mem_init = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mem_init = 1'b0;

    chk("rst_state",     dut.state,     IDLE);
    chk("rst_cs",        ram_cs,        1'b0);
    chk("rst_we",        ram_we,        1'b0);
    chk("rst_oe",        ram_oe,        1'b0);
    chk("rst_addr",      ram_addr,      8'h00);
    chk("rst_wdata",     ram_wdata,     32'h0);
    chk("rst_rsp_valid", bus.rsp_valid, 2'b00);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].we) do_write(vecs[i].client, vecs[i].addr, vecs[i].wdata);
      else            do_read(vecs[i].client, vecs[i].addr, vecs[i].exp_rdata, 0);
    end

    // Back-pressured response.
    do_read(0, 8'h10, 32'hDEAD_BEEF, 5);

    // Both clients request writes continuously, four each.
    cnt[0] = 0;
    cnt[1] = 0;
    bus.req_we       = 2'b11;
    bus.req_addr[0]  = 8'h20;
    bus.req_wdata[0] = 32'hC000_0000;
    bus.req_addr[1]  = 8'h30;
    bus.req_wdata[1] = 32'hC100_0000;
    bus.req_valid    = 2'b11;
    for (int cyc = 0; cyc < 60 && (cnt[0] < 4 || cnt[1] < 4); cyc++) begin
      logic [1:0] hs;
      @(negedge clk);
      hs = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      for (int c = 0; c < 2; c++) begin
        if (hs[c]) begin
          order.push_back(c);
          cnt[c]++;
          bus.req_addr[c]  = bus.req_addr[c] + 8'h1;
          bus.req_wdata[c] = bus.req_wdata[c] + 32'h1;
          bus.req_valid[c] = (cnt[c] < 4);
        end
      end
    end
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("arb_count", order.size(), 8);
    for (int i = 0; i < 8 && i < order.size(); i++) begin
`ifdef RAM_CTRL_RR_EN
      if (i > 0) chk("rr_alternate", order[i], 1 - order[i-1]);
`else
      chk("fixed_order", order[i], (i < 4) ? 0 : 1);
`endif
    end
    for (int i = 0; i < 4; i++) begin
      chk("arb_mem_c0", mem[8'h20 + i], 32'hC000_0000 + 32'(i));
      chk("arb_mem_c1", mem[8'h30 + i], 32'hC100_0000 + 32'(i));
    end
    do_read(1, 8'h23, 32'hC000_0003, 0);

    // Reset arriving while a read sits in RD1.
    bus.rsp_ready   = 2'b11;
    bus.req_valid   = 2'b01;
    bus.req_we[0]   = 1'b0;
    bus.req_addr[0] = 8'h10;
    begin
      bit ok;
      wait_grant(0, ok);
      bus.req_valid = '0;
      if (ok) begin
        chk("rstrd_rd0", dut.state, RD0);
        @(posedge clk);
        #1;
        chk("rstrd_rd1", dut.state, RD1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rstrd_state",     dut.state,     IDLE);
        chk("rstrd_cs",        ram_cs,        1'b0);
        chk("rstrd_rsp_valid", bus.rsp_valid, 2'b00);
        for (int k = 0; k < 6; k++) begin
          @(posedge clk);
          #1;
          chk("rstrd_no_rsp", bus.rsp_valid, 2'b00);
        end
      end
    end

    // Controller usable again after the mid-read reset; 0xFF still holds its write.
    do_read(1, 8'hFF, 32'h0000_0005, 0);
    do_read(0, 8'h00, 32'hA500_0000, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
